aes_out_serializer: RTL and testbench
=====================================

AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of 128-bit block entries buffered (power of 2, 2..8).
REQ-002 SHALL have parameter MSW_FIRST, default 1, word order (1: bits [127:96] first; 0: bits [31:0] first).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port blk_data  input  128  result block from the AES core (cipher_text_128).
REQ-006 SHALL have port blk_valid  input  1  one-cycle strobe, blk_data valid (AES core valid_out).
REQ-007 SHALL have port word_data  output  32  current output word.
REQ-008 SHALL have port word_valid  output  1  word_data valid.
REQ-009 SHALL have port word_ready  input  1  downstream accepts word this cycle.
REQ-010 SHALL have port word_last  output  1  marks the 4th word of a block.
REQ-011 SHALL have port fifo_count  output  $clog2(DEPTH)+1  blocks currently buffered.
REQ-012 SHALL have port overflow  output  1  sticky: a block was dropped.

Function
REQ-013 SHALL store blk_data into the FIFO tail on a rising edge where blk_valid=1 and a write is permitted.
REQ-014 SHALL permit a write when fifo_count<DEPTH, or when fifo_count=DEPTH and the last word of the head block handshakes in the same cycle.
REQ-015 SHALL drop blk_data and set overflow=1 when blk_valid=1 and the write is not permitted; FIFO contents unchanged.
REQ-016 SHALL run a 2-state FSM: IDLE (fifo_count=0) and SEND (fifo_count>0); IDLE->SEND on write; SEND->IDLE on last-word pop with no simultaneous write and fifo_count=1.
REQ-017 SHALL drive word_valid=1 exactly in SEND; word_data/word_last combinational from head entry and a 2-bit word index.
REQ-018 SHALL select word index i (0..3) as bits [127-32i -: 32] when MSW_FIRST=1, else [32i +: 32].
REQ-019 SHALL advance the word index on word_valid&&word_ready, wrapping 3->0 and popping the head on the wrap.
REQ-020 SHALL assert word_last when word index=3 and word_valid=1.
REQ-021 SHALL hold word_data, word_last and word index stable while word_valid=1 and word_ready=0.
REQ-022 SHALL give latency one cycle: block written at edge N -> word_valid=1 with word 0 after edge N when the FIFO was empty.
REQ-023 SHALL on simultaneous write and pop leave fifo_count unchanged; read/write pointers wrap modulo DEPTH.
REQ-024 SHALL keep overflow set until reset.

Reset
REQ-025 SHALL on reset=0, asynchronously: FSM=IDLE, pointers=0, word index=0, fifo_count=0, word_valid=0, word_last=0, overflow=0, drop_count=0 (if present); word_data=0.
REQ-026 SHALL discard all buffered blocks and any partly sent block on reset mid-operation; no word output until a new blk_valid after release.
REQ-027 SHALL not require FIFO storage array to be reset.

Configuration
REQ-028 SHALL, with macro AES_OUT_DROP_CNT_EN defined, add output drop_count (16 bits) counting dropped blocks, saturating at 16'hFFFF.
REQ-029 SHALL, without AES_OUT_DROP_CNT_EN, omit drop_count port and counter; all other behaviour identical.

Verification
REQ-030 SHALL cover single block: blk_data=128'h00112233_44556677_8899AABB_CCDDEEFF, word_ready=1, MSW_FIRST=1 -> words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles, word_last on 4th, fifo_count back to 0.
REQ-031 SHALL cover backpressure: word_ready=0 for 5 cycles after word 1 -> word_data held at 44556677, no word skipped or repeated.
REQ-032 SHALL cover overflow: DEPTH=2, word_ready=0, 3 blk_valid strobes -> fifo_count=2, overflow=1, drop_count=1 (macro on), third block never output.
REQ-033 SHALL cover full-with-pop: fifo_count=2, blk_valid coincident with word_last handshake -> block accepted, overflow stays 0, fifo_count stays 2.
REQ-034 SHALL cover reset mid-block: reset=0 after word 2 of a block -> word_valid=0 immediately, fifo_count=0; next block starts at word 0.
REQ-035 SHALL cover MSW_FIRST=0 with REQ-030 data -> first word CCDDEEFF, last word 00112233.

Source files
------------

// File: rtl/aes_out_serializer.sv
// Buffers 128-bit AES result blocks in a small FIFO and streams each one out as four 32-bit words.
// Optional macro AES_OUT_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module aes_out_serializer #(
  parameter int DEPTH     = 2,
  parameter int MSW_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [127:0]             blk_data,
  input  logic                     blk_valid,
  output logic [31:0]              word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     word_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
`ifdef AES_OUT_DROP_CNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [1:0]      word_idx;
  logic [127:0]    mem [DEPTH];

  logic            pop;
  logic            full;
  logic            wr_en;
  logic            drop;
  logic [1:0]      lane;
  logic [127:0]    head;

  assign pop   = word_valid && word_ready && (word_idx == 2'd3);
  assign full  = (fifo_count == CW'(DEPTH));
  // A full FIFO still takes a block when the head's last word leaves this cycle.
  assign wr_en = blk_valid && (!full || pop);
  assign drop  = blk_valid && !wr_en;

  assign head      = mem[rd_ptr];
  assign lane      = (MSW_FIRST != 0) ? (2'd3 - word_idx) : word_idx;
  assign word_data = word_valid ? head[{lane, 5'b0} +: 32] : 32'h0;
  assign word_last = word_valid && (word_idx == 2'd3);

  // Storage is not reset; reads are masked by word_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= blk_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      word_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      word_idx   <= 2'd0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (word_valid && word_ready) word_idx <= word_idx + 2'd1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (wr_en) begin
            state      <= SEND;
            word_valid <= 1'b1;
          end
        end
        SEND: begin
          if (pop && !wr_en && (fifo_count == CW'(1))) begin
            state      <= IDLE;
            word_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          word_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_OUT_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= 16'h0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer: one MSW-first and one LSW-first instance share stimulus.
module tb_aes_out_serializer;

  logic         clk;
  logic         reset;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         word_ready;

  logic [31:0]  m_data, l_data;
  logic         m_valid, l_valid;
  logic         m_last, l_last;
  logic [1:0]   m_count, l_count;
  logic         m_ovf, l_ovf;
`ifdef AES_OUT_DROP_CNT_EN
  logic [15:0]  m_drop, l_drop;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] BLK0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLKA = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
  localparam logic [127:0] BLKB = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
  localparam logic [127:0] BLKC = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] BLKD = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
  localparam logic [127:0] BLKE = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;

  aes_out_serializer #(.DEPTH(2), .MSW_FIRST(1)) u_msw (
    .clk(clk), .reset(reset), .blk_data(blk_data), .blk_valid(blk_valid),
    .word_data(m_data), .word_valid(m_valid), .word_ready(word_ready),
    .word_last(m_last), .fifo_count(m_count), .overflow(m_ovf)
`ifdef AES_OUT_DROP_CNT_EN
    , .drop_count(m_drop)
`endif
  );

  aes_out_serializer #(.DEPTH(2), .MSW_FIRST(0)) u_lsw (
    .clk(clk), .reset(reset), .blk_data(blk_data), .blk_valid(blk_valid),
    .word_data(l_data), .word_valid(l_valid), .word_ready(word_ready),
    .word_last(l_last), .fifo_count(l_count), .overflow(l_ovf)
`ifdef AES_OUT_DROP_CNT_EN
    , .drop_count(l_drop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input logic [127:0] b, input int i, input bit msw);
    logic [127:0] s;
    s = msw ? (b >> (96 - 32 * i)) : (b >> (32 * i));
    return s[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d);
    blk_data  = d;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; blk_valid = 1'b0; blk_data = '0; word_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_count !== 2'd0 || m_ovf !== 1'b0 || m_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_msw: valid=%b last=%b count=%0d ovf=%b data=%h, required 0 0 0 0 0", m_valid, m_last, m_count, m_ovf, m_data);
    end
    checks++;
    if (l_valid !== 1'b0 || l_count !== 2'd0 || l_ovf !== 1'b0 || l_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_lsw: valid=%b count=%0d ovf=%b data=%h, required 0 0 0 0", l_valid, l_count, l_ovf, l_data);
    end
`ifdef AES_OUT_DROP_CNT_EN
    checks++;
    if (m_drop !== 16'h0) begin
      errors++;
      $display("FAIL reset_drop: got %h, required 0000", m_drop);
    end
`endif
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [31:0] msw_w [4];
    logic [31:0] lsw_w [4];
    msw_w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    lsw_w = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    word_ready = 1'b1;
    push(BLK0);
    checks++;
    if (m_count !== 2'd1) begin
      errors++;
      $display("FAIL single_count: got %0d, required 1", m_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== msw_w[i] || m_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_msw_w%0d: valid=%b data=%h last=%b, required 1 %h %b", i, m_valid, m_data, m_last, msw_w[i], (i == 3));
      end
      checks++;
      if (l_valid !== 1'b1 || l_data !== lsw_w[i] || l_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_lsw_w%0d: valid=%b data=%h last=%b, required 1 %h %b", i, l_valid, l_data, l_last, lsw_w[i], (i == 3));
      end
      step();
    end
    checks++;
    if (m_valid !== 1'b0 || m_count !== 2'd0 || l_valid !== 1'b0 || l_count !== 2'd0) begin
      errors++;
      $display("FAIL single_idle: valid=%b/%b count=%0d/%0d, required 0 0", m_valid, l_valid, m_count, l_count);
    end
  endtask

  task automatic test_backpressure();
    word_ready = 1'b1;
    push(BLK0);
    checks++;
    if (m_data !== 32'h00112233) begin
      errors++;
      $display("FAIL bp_w0: got %h, required 00112233", m_data);
    end
    step();
    word_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'h44556677 || m_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h last=%b, required 1 44556677 0", c, m_valid, m_data, m_last);
      end
      step();
    end
    checks++;
    if (m_data !== 32'h44556677) begin
      errors++;
      $display("FAIL bp_hold_final: got %h, required 44556677", m_data);
    end
    word_ready = 1'b1;
    step();
    checks++;
    if (m_data !== 32'h8899AABB || m_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_w2: data=%h last=%b, required 8899aabb 0", m_data, m_last);
    end
    step();
    checks++;
    if (m_data !== 32'hCCDDEEFF || m_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_w3: data=%h last=%b, required ccddeeff 1", m_data, m_last);
    end
    step();
    checks++;
    if (m_valid !== 1'b0 || m_count !== 2'd0) begin
      errors++;
      $display("FAIL bp_idle: valid=%b count=%0d, required 0 0", m_valid, m_count);
    end
  endtask

  task automatic test_full_pop();
    logic [127:0] blks [2];
    blks = '{BLKB, BLKC};
    word_ready = 1'b0;
    push(BLKA);
    push(BLKB);
    checks++;
    if (m_count !== 2'd2 || m_data !== 32'hA0A0A0A0) begin
      errors++;
      $display("FAIL fp_full: count=%0d data=%h, required 2 a0a0a0a0", m_count, m_data);
    end
    word_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (m_last !== 1'b1 || m_data !== 32'hA3A3A3A3) begin
      errors++;
      $display("FAIL fp_a_last: last=%b data=%h, required 1 a3a3a3a3", m_last, m_data);
    end
    push(BLKC);
    checks++;
    if (m_count !== 2'd2 || m_ovf !== 1'b0 || l_ovf !== 1'b0) begin
      errors++;
      $display("FAIL fp_accept: count=%0d ovf=%b/%b, required 2 0", m_count, m_ovf, l_ovf);
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== exp_word(blks[b], i, 1'b1) || l_data !== exp_word(blks[b], i, 1'b0)) begin
          errors++;
          $display("FAIL fp_drain_b%0d_w%0d: valid=%b msw=%h lsw=%h, required 1 %h %h", b, i, m_valid, m_data, l_data,
                   exp_word(blks[b], i, 1'b1), exp_word(blks[b], i, 1'b0));
        end
        step();
      end
    end
    checks++;
    if (m_valid !== 1'b0 || m_count !== 2'd0 || m_ovf !== 1'b0) begin
      errors++;
      $display("FAIL fp_idle: valid=%b count=%0d ovf=%b, required 0 0 0", m_valid, m_count, m_ovf);
    end
  endtask

  task automatic test_overflow();
    logic [127:0] blks [2];
    blks = '{BLKA, BLKB};
    word_ready = 1'b0;
    push(BLKA);
    push(BLKB);
    checks++;
    if (m_count !== 2'd2 || m_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre: count=%0d ovf=%b, required 2 0", m_count, m_ovf);
    end
    push(BLKC);
    checks++;
    if (m_count !== 2'd2 || m_ovf !== 1'b1 || l_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: count=%0d ovf=%b/%b, required 2 1", m_count, m_ovf, l_ovf);
    end
`ifdef AES_OUT_DROP_CNT_EN
    checks++;
    if (m_drop !== 16'd1) begin
      errors++;
      $display("FAIL ovf_drop_count: got %0d, required 1", m_drop);
    end
`endif
    word_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== exp_word(blks[b], i, 1'b1)) begin
          errors++;
          $display("FAIL ovf_drain_b%0d_w%0d: valid=%b data=%h, required 1 %h", b, i, m_valid, m_data, exp_word(blks[b], i, 1'b1));
        end
        step();
      end
    end
    repeat (2) step();
    checks++;
    if (m_valid !== 1'b0 || m_count !== 2'd0 || m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: valid=%b count=%0d ovf=%b, required 0 0 1", m_valid, m_count, m_ovf);
    end
  endtask

  task automatic test_reset_mid();
    word_ready = 1'b1;
    push(BLKD);
    step();
    step();
    checks++;
    if (m_data !== 32'hD2D2D2D2) begin
      errors++;
      $display("FAIL rm_w2: got %h, required d2d2d2d2", m_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_count !== 2'd0 || m_ovf !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL rm_async: valid=%b count=%0d ovf=%b data=%h last=%b, required 0 0 0 0 0", m_valid, m_count, m_ovf, m_data, m_last);
    end
`ifdef AES_OUT_DROP_CNT_EN
    checks++;
    if (m_drop !== 16'h0) begin
      errors++;
      $display("FAIL rm_drop_count: got %h, required 0000", m_drop);
    end
`endif
    step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (m_valid !== 1'b0 || l_valid !== 1'b0) begin
        errors++;
        $display("FAIL rm_quiet%0d: valid=%b/%b, required 0", c, m_valid, l_valid);
      end
    end
    push(BLKE);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_word(BLKE, i, 1'b1) || m_last !== (i == 3)) begin
        errors++;
        $display("FAIL rm_new_w%0d: valid=%b data=%h last=%b, required 1 %h %b", i, m_valid, m_data, m_last, exp_word(BLKE, i, 1'b1), (i == 3));
      end
      step();
    end
    checks++;
    if (m_valid !== 1'b0 || m_count !== 2'd0) begin
      errors++;
      $display("FAIL rm_idle: valid=%b count=%0d, required 0 0", m_valid, m_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_pop();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
